// File: rtl/ipml_fifo_pkg.sv
// Shared helpers and legal-range limits for the ipml FIFO read-side blocks.
// No logic, so no latency.
// No flow control; the parameter-check macro stops elaboration on an illegal configuration.
package ipml_fifo_pkg;

    localparam int RAM_LAT_MAX  = 2;
    localparam int PF_DEPTH_MAX = 16;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// Expands to a generate block that stops elaboration on an unsupported configuration.
`define IPML_PF_PARAM_CHECK(WIDTH, LAT, DEPTH) \
    if ((WIDTH) < 1 || (WIDTH) > 1152 || (LAT) < 1 || (LAT) > ipml_fifo_pkg::RAM_LAT_MAX || \
        (DEPTH) < (LAT) + 1 || (DEPTH) > ipml_fifo_pkg::PF_DEPTH_MAX) begin : g_param_check \
        $fatal(1, "ipml prefetch: illegal DATA_W/RAM_LAT/PF_DEPTH combination"); \
    end

// File: rtl/ipml_prefetch_buf_v2_0.sv
// Circular register buffer: wrap-around pointers, occupancy count and the entry array.
// Write lands at the clock edge; the head entry drives rd_data straight from the array.
// No internal backpressure; the caller never writes a full buffer unless it pops in the same cycle.
module ipml_prefetch_buf_v2_0
    import ipml_fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PF_DEPTH = 4,
    parameter int CNT_W    = clog2(PF_DEPTH + 1)
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (PF_DEPTH > 1) ? clog2(PF_DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [PF_DEPTH];
    logic [DATA_W-1:0] mem_d [PF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Depth need not be a power of two, so wrap explicitly at the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(PF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Array update: a flush drops the word arriving at the same edge.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && !clr) begin
            mem_d[wr_ptr_q] = wr_data;
        end
    end

    // Pointer and occupancy update; simultaneous write and pop leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers, cleared asynchronously so stale data never reaches rd_data.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < PF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // A write into a full buffer is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(wr_en && !pop && !clr && count_q == CNT_W'(PF_DEPTH)));

endmodule

// File: rtl/ipml_prefetch_rd_ctrl_v2_0.sv
// FWFT prefetch between a RAM-based FIFO core and a valid/ready consumer, credit-based issue.
// core_rd_en in cycle t gives rd_vld in cycle t+RAM_LAT+1; one word per cycle sustained.
// Issues only while buffered + in-flight words leave room; a same-cycle pop returns a credit.
module ipml_prefetch_rd_ctrl_v2_0
    import ipml_fifo_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  RAM_LAT  = 1,
    parameter int  PF_DEPTH = 4,
    localparam int CNT_W    = clog2(PF_DEPTH + 1)
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              core_empty,
    output logic              core_rd_en,
    input  logic [DATA_W-1:0] core_rd_data,
    input  logic              flush,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic [CNT_W-1:0]  pf_count
);

    `IPML_PF_PARAM_CHECK(DATA_W, RAM_LAT, PF_DEPTH)

    logic [RAM_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [CNT_W:0]     inflight;
    logic [CNT_W:0]     credit_need;
    logic               arrival;
    logic               pop;

    assign rd_vld  = (pf_count != '0);
    assign pop     = rd_vld & rd_en;
    assign arrival = vld_pipe_q[RAM_LAT-1];

    // Count reads already issued whose data has not yet landed in the buffer.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            inflight = inflight + (CNT_W + 1)'(vld_pipe_q[i]);
        end
    end

    // The pop credit is taken in the same cycle, so rd_en reaches core_rd_en combinationally.
    assign credit_need = (CNT_W + 1)'(pf_count) + inflight - (CNT_W + 1)'(pop);
    assign core_rd_en  = ~rd_rst & ~core_empty & ~flush
                       & (credit_need < (CNT_W + 1)'(PF_DEPTH));

    // In-flight tracker mirrors the core read latency; a flush kills every pending arrival.
    always_comb begin
        vld_pipe_d = '0;
        if (!flush) begin
            vld_pipe_d[0] = core_rd_en;
            for (int i = 1; i < RAM_LAT; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
            end
        end
    end

    // In-flight register; reset clears it so late core data is never captured.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
        end
    end

    ipml_prefetch_buf_v2_0 #(
        .DATA_W   (DATA_W),
        .PF_DEPTH (PF_DEPTH),
        .CNT_W    (CNT_W)
    ) u_buf (
        .rd_clk   (rd_clk),
        .rd_rst   (rd_rst),
        .clr      (flush),
        .wr_en    (arrival),
        .wr_data  (core_rd_data),
        .pop      (pop),
        .rd_data  (rd_data),
        .count    (pf_count)
    );

endmodule

// File: tb/tb_ipml_prefetch_rd_ctrl_v2_0.sv
// Directed bench: three configurations (lat1/depth4, lat2/depth3, lat2/depth5) with simple core models.
// Hand-computed cycle expectations plus pop logs compared against known word sequences.
// Consumer rd_en is driven per test; some phases randomise it, with order checked via the pop log.
module tb_ipml_prefetch_rd_ctrl_v2_0;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b1;
    always #5 rd_clk = ~rd_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- instance A: RAM_LAT=1, PF_DEPTH=4 ----------------
    logic        core_empty_a, core_rd_en_a, flush_a = 1'b0, rd_en_a = 1'b0, rd_vld_a;
    logic [31:0] core_rd_data_a, rd_data_a;
    logic [2:0]  pf_count_a;
    logic [31:0] mem_a [64];
    int          wr_a = 0, rd_a = 0;
    logic [31:0] cd1_a = '0;
    logic [31:0] log_a [64];
    int          n_a = 0;

    assign core_empty_a   = (rd_a == wr_a);
    assign core_rd_data_a = cd1_a;
    always @(posedge rd_clk) begin
        if (core_rd_en_a) rd_a <= rd_a + 1;
        cd1_a <= mem_a[rd_a % 64];
    end
    always @(negedge rd_clk) begin
        if (rd_vld_a && rd_en_a) begin
            log_a[n_a % 64] <= rd_data_a;
            n_a <= n_a + 1;
        end
    end

    ipml_prefetch_rd_ctrl_v2_0 #(.DATA_W(32), .RAM_LAT(1), .PF_DEPTH(4)) dut_a (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .core_empty(core_empty_a), .core_rd_en(core_rd_en_a),
        .core_rd_data(core_rd_data_a), .flush(flush_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
        .rd_vld(rd_vld_a), .pf_count(pf_count_a));

    // ---------------- instance B: RAM_LAT=2, PF_DEPTH=3 ----------------
    logic        core_empty_b, core_rd_en_b, flush_b = 1'b0, rd_en_b = 1'b0, rd_vld_b;
    logic [31:0] core_rd_data_b, rd_data_b;
    logic [1:0]  pf_count_b;
    logic [31:0] mem_b [64];
    int          wr_b = 0, rd_b = 0, pulses_b = 0;
    logic [31:0] cd1_b = '0, cd2_b = '0;

    assign core_empty_b   = (rd_b == wr_b);
    assign core_rd_data_b = cd2_b;
    always @(posedge rd_clk) begin
        if (core_rd_en_b) rd_b <= rd_b + 1;
        cd1_b <= mem_b[rd_b % 64];
        cd2_b <= cd1_b;
    end
    always @(negedge rd_clk) begin
        if (core_rd_en_b) pulses_b <= pulses_b + 1;
    end

    ipml_prefetch_rd_ctrl_v2_0 #(.DATA_W(32), .RAM_LAT(2), .PF_DEPTH(3)) dut_b (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .core_empty(core_empty_b), .core_rd_en(core_rd_en_b),
        .core_rd_data(core_rd_data_b), .flush(flush_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
        .rd_vld(rd_vld_b), .pf_count(pf_count_b));

    // ---------------- instance C: RAM_LAT=2, PF_DEPTH=5 ----------------
    logic        core_empty_c, core_rd_en_c, flush_c = 1'b0, rd_en_c = 1'b0, rd_vld_c;
    logic [31:0] core_rd_data_c, rd_data_c;
    logic [2:0]  pf_count_c;
    logic [31:0] mem_c [64];
    int          wr_c = 0, rd_c = 0, n_c = 0;
    logic [31:0] cd1_c = '0, cd2_c = '0;
    logic [31:0] log_c [64];
    logic [2:0]  max_c = '0;

    assign core_empty_c   = (rd_c == wr_c);
    assign core_rd_data_c = cd2_c;
    always @(posedge rd_clk) begin
        if (core_rd_en_c) rd_c <= rd_c + 1;
        cd1_c <= mem_c[rd_c % 64];
        cd2_c <= cd1_c;
    end
    always @(negedge rd_clk) begin
        if (rd_vld_c && rd_en_c) begin
            log_c[n_c % 64] <= rd_data_c;
            n_c <= n_c + 1;
        end
        if (pf_count_c > max_c) max_c <= pf_count_c;
    end

    ipml_prefetch_rd_ctrl_v2_0 #(.DATA_W(32), .RAM_LAT(2), .PF_DEPTH(5)) dut_c (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .core_empty(core_empty_c), .core_rd_en(core_rd_en_c),
        .core_rd_data(core_rd_data_c), .flush(flush_c), .rd_en(rd_en_c), .rd_data(rd_data_c),
        .rd_vld(rd_vld_c), .pf_count(pf_count_c));

    // Hard stop if something hangs.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        // B's core is preloaded during reset: core_empty=0 yet no request may issue.
        for (int i = 0; i < 10; i++) mem_b[i] = 32'hB0 + i;
        wr_b = 10;
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("rst_vld_a", rd_vld_a, 0);
        chk("rst_cnt_a", pf_count_a, 0);
        chk("rst_data_a", rd_data_a, 0);
        chk("rst_rden_b", core_rd_en_b, 0);

        // A: 8 words, consumer always ready, FWFT latency 2 and no bubbles.
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        for (int i = 0; i < 8; i++) mem_a[i] = 32'h10 + i;
        wr_a = 8;
        rd_en_a = 1'b1;
        @(negedge rd_clk);
        chk("a_issue_t0", core_rd_en_a, 1);
        chk("a_vld_t0", rd_vld_a, 0);
        @(negedge rd_clk);
        chk("a_vld_t1", rd_vld_a, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge rd_clk);
            chk($sformatf("a_vld_w%0d", i), rd_vld_a, 1);
            chk($sformatf("a_data_w%0d", i), rd_data_a, 32'h10 + i);
        end
        @(negedge rd_clk);
        chk("a_vld_drain", rd_vld_a, 0);
        chk("a_pops", n_a, 8);

        // B: no consumer, exactly PF_DEPTH requests.
        chk("b_pulses_fill", pulses_b, 3);
        chk("b_cnt_full", pf_count_b, 3);
        chk("b_head", rd_data_b, 32'hB0);
        chk("b_vld_full", rd_vld_b, 1);
        @(posedge rd_clk); #1;
        rd_en_b = 1'b1;
        @(negedge rd_clk);
        chk("b_pop_credit_issue", core_rd_en_b, 1);
        @(posedge rd_clk); #1;
        rd_en_b = 1'b0;
        @(negedge rd_clk);
        chk("b_cnt_p1", pf_count_b, 2);
        chk("b_head_p1", rd_data_b, 32'hB1);
        @(negedge rd_clk);
        chk("b_cnt_p2", pf_count_b, 2);
        @(negedge rd_clk);
        chk("b_cnt_p3", pf_count_b, 3);
        chk("b_pulses_p3", pulses_b, 4);

        // B flush with two buffered and one in flight; pop during flush is ignored.
        @(posedge rd_clk); #1;
        rd_en_b = 1'b1;
        @(posedge rd_clk); #1;
        flush_b = 1'b1;
        @(negedge rd_clk);
        chk("b_flush_cnt_before", pf_count_b, 2);
        chk("b_flush_no_issue", core_rd_en_b, 0);
        @(posedge rd_clk); #1;
        flush_b = 1'b0;
        rd_en_b = 1'b0;
        @(negedge rd_clk);
        chk("b_flush_vld", rd_vld_b, 0);
        chk("b_flush_cnt", pf_count_b, 0);
        chk("b_flush_reissue", core_rd_en_b, 1);
        @(negedge rd_clk);
        chk("b_late_drop1", rd_vld_b, 0);
        @(negedge rd_clk);
        chk("b_late_drop2", rd_vld_b, 0);
        @(negedge rd_clk);
        chk("b_post_flush_vld", rd_vld_b, 1);
        chk("b_post_flush_data", rd_data_b, 32'hB5);

        // C: depth 5, fill first, then random consumer across pointer wrap.
        @(posedge rd_clk); #1;
        for (int i = 0; i < 12; i++) mem_c[i] = 32'hC0 + i;
        wr_c = 12;
        repeat (12) @(posedge rd_clk);
        #1;
        for (int i = 0; i < 300 && n_c < 12; i++) begin
            rd_en_c = 1'($urandom_range(0, 1));
            @(posedge rd_clk); #1;
        end
        rd_en_c = 1'b0;
        chk("c_pops", n_c, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("c_order%0d", i), log_c[i], 32'hC0 + i);
        chk("c_max_cnt", max_c, 5);

        // A: reset mid-stream while holding data.
        @(posedge rd_clk); #1;
        rd_en_a = 1'b0;
        for (int i = 0; i < 8; i++) mem_a[8 + i] = 32'h20 + i;
        wr_a = 16;
        repeat (8) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("a_prerst_cnt", pf_count_a, 4);
        chk("a_prerst_data", rd_data_a, 32'h20);
        #2;
        rd_rst = 1'b1;
        #1;
        chk("a_async_vld", rd_vld_a, 0);
        chk("a_async_cnt", pf_count_a, 0);
        chk("a_async_data", rd_data_a, 0);
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        @(negedge rd_clk);
        chk("a_rel_issue", core_rd_en_a, 1);
        chk("a_rel_vld0", rd_vld_a, 0);
        @(negedge rd_clk);
        chk("a_rel_vld1", rd_vld_a, 0);
        @(negedge rd_clk);
        chk("a_rel_vld2", rd_vld_a, 1);
        chk("a_rel_data", rd_data_a, 32'h24);
        chk("a_rel_cnt", pf_count_a, 1);
        repeat (6) @(posedge rd_clk);

        // A: core_empty toggles every cycle while the consumer is always ready.
        #1;
        rd_en_a = 1'b1;
        st = n_a;
        for (int k = 0; k < 8; k++) begin
            mem_a[16 + k] = 32'h30 + k;
            wr_a = 17 + k;
            @(posedge rd_clk); #1;
            @(posedge rd_clk); #1;
        end
        for (int i = 0; i < 100 && (n_a - st) < 12; i++) @(posedge rd_clk);
        repeat (2) @(posedge rd_clk);
        chk("a_tog_pops", n_a - st, 12);
        for (int i = 0; i < 4; i++) chk($sformatf("a_tog_old%0d", i), log_a[(st + i) % 64], 32'h24 + i);
        for (int i = 0; i < 8; i++) chk($sformatf("a_tog_new%0d", i), log_a[(st + 4 + i) % 64], 32'h30 + i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ipml_prefetch_rd_ctrl_v2_0.md
Name: ipml_prefetch_rd_ctrl_v2_0

Overview:
- Read-side prefetch engine between a RAM-based FIFO core and a valid/ready consumer.
- The core provides an empty flag, accepts a read enable, and returns data a fixed RAM_LAT cycles later.
- Presents first-word-fall-through (FWFT) data through a parametrised depth-PF_DEPTH output buffer, with credit-based issue so throughput never stalls.
- Successor to the fixed depth-2, latency-1 prefetch scheme; adds configurable RAM latency (output register on/off), configurable buffer depth, a flush, and an occupancy output.

Parameters:
- DATA_W, 32, data width, 1..1152
- RAM_LAT, 1, core read latency in cycles, 1 or 2 (2 = RAM output register enabled)
- PF_DEPTH, 4, output buffer entries, RAM_LAT+1..16; need not be a power of 2
- CNT_W, clog2(PF_DEPTH+1), occupancy counter width (derived; not user-set)

Ports:
- rd_clk  in  1  read clock
- rd_rst  in  1  reset, asynchronous, active-high; clock rd_clk
- core_empty  in  1  core empty flag, registered in core
- core_rd_en  out  1  read request to core; combinational
- core_rd_data  in  DATA_W  core data, valid RAM_LAT cycles after core_rd_en sampled
- flush  in  1  synchronous discard of buffered and in-flight words
- rd_en  in  1  consumer ready
- rd_data  out  DATA_W  head-of-buffer word
- rd_vld  out  1  rd_data valid
- pf_count  out  CNT_W  words currently held in buffer

Behaviour:
- Reset values: rd_vld=0, pf_count=0, rd_data=0, pointers=0, in-flight pipe=0. core_rd_en is 0 during reset.
- pop = rd_vld & rd_en. rd_en while rd_vld=0 is ignored.
- Credit:
  - inflight = popcount of valid pipe vld_pipe[RAM_LAT-1:0].
  - core_rd_en = ~core_empty & ~flush & ((pf_count + inflight - pop) < PF_DEPTH).
  - The same-cycle pop credit is intentional: a combinational path rd_en -> core_rd_en exists.
- In-flight pipe: vld_pipe shifts each cycle with vld_pipe[0] <= core_rd_en. Word arrival is vld_pipe[RAM_LAT-1]=1.
- Arrival write: at that edge, core_rd_data is written at wr_ptr, and wr_ptr advances with explicit wrap at PF_DEPTH-1 -> 0.
- Pop: rd_ptr advances with the same wrap. rd_data is the entry at rd_ptr, driven from the register array with no extra stage.
- pf_count:
  - +1 on arrival only.
  - -1 on pop only.
  - Unchanged on simultaneous arrival and pop.
  - rd_vld = (pf_count != 0).
- Latency: core_rd_en high in cycle t -> data captured at end of cycle t+RAM_LAT -> rd_vld in cycle t+RAM_LAT+1. For RAM_LAT=1, the first word is visible 2 cycles after core_empty falls.
- Throughput: with PF_DEPTH >= RAM_LAT+1 and rd_en held high, one word per cycle is sustained with no bubbles.
- Full boundary:
  - pf_count + inflight never exceeds PF_DEPTH. An arrival with pf_count==PF_DEPTH is illegal; an assertion is required.
  - Arrival and pop in the same cycle at pf_count==PF_DEPTH can only occur if the credit was taken via pop. This is legal and pf_count stays at PF_DEPTH.
- Empty boundary: with pf_count==0, an arrival makes rd_vld high the next cycle. There is no combinational bypass from core_rd_data to rd_data.
- Flush (cycle f):
  - core_rd_en=0 in cycle f.
  - pf_count, pointers and vld_pipe are cleared at the edge ending f.
  - Words arriving at that edge are dropped.
  - rd_vld=0 in f+1.
  - pop in cycle f is ignored.
  - Words already read from the core are lost by design.
- Reset mid-operation: all state is cleared asynchronously. Late core data is never captured because vld_pipe is cleared. The core must share rd_rst.
- core_empty may rise in the same cycle a request is issued; core_rd_en drops combinationally.

Decomposition:
- Shared package ipml_fifo_pkg:
  - clog2 function
  - legal-range constants: RAM_LAT_MAX=2, PF_DEPTH_MAX=16
  - parameter-check macro, fatal at elaboration if PF_DEPTH < RAM_LAT+1
- Sub-module ipml_prefetch_buf_v2_0: circular register buffer (wr/rd pointers with wrap, count, array).
- Top level: credit logic, vld_pipe, flush.

Test Plan:
- RAM_LAT=1, PF_DEPTH=4, preload 8 words 0x10..0x17, rd_en=1 from start -> rd_vld rises 2 cycles after core_empty=0; 0x10..0x17 appear on 8 consecutive cycles with no bubble.
- RAM_LAT=2, PF_DEPTH=3, rd_en=0, 10 words queued -> exactly 3 core_rd_en pulses; pf_count=3; rd_data=first word. Then rd_en=1 for 1 cycle -> exactly one new core_rd_en in that same cycle; pf_count returns to 3 two cycles later.
- PF_DEPTH=5 (non-power-of-2), 12 words, random rd_en -> order preserved across pointer wrap 4 -> 0; pf_count never exceeds 5.
- Flush asserted while pf_count=2 and inflight=1 -> next cycle rd_vld=0, pf_count=0; the late core word is not captured; the next issued word is delivered normally.
- rd_rst pulsed mid-stream while rd_vld=1 -> rd_vld=0 and pf_count=0 immediately (asynchronously); after release, normal FWFT latency is repeated.
- core_empty toggling every cycle with rd_en=1 -> no duplicated or lost words; scoreboard matches.
